alu_op_issuer: RTL and testbench



---
 rtl/alu_op_issuer.sv | 143 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_issuer
// Brief   : Decodes opcode/funct into ALU control. Holds multi-cycle
//           mul/div ops before issuing them over a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_issuer #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] alu_control,
    output logic       alu_src_imm,
    output logic       illegal
);

    localparam logic [3:0] c_mul_cycles = 4'(MUL_CYCLES);
    localparam logic [3:0] c_div_cycles = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [5:0] r_ctrl;
    logic       r_imm;
    logic       r_ill;
    logic [5:0] w_dec_ctrl;
    logic       w_dec_imm;
    logic       w_dec_ill;
    logic       w_dec_div;
    logic       w_dec_mul;
    logic       w_accept;

    // Acceptance depends only on state and out_ready, never on in_valid.
    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == ST_HOLD);
    assign alu_control = r_ctrl;
    assign alu_src_imm = r_imm;
    assign illegal     = r_ill;

    always_comb begin
        w_dec_ctrl = 6'b000000;
        w_dec_imm  = 1'b0;
        w_dec_ill  = 1'b0;
        w_dec_div  = 1'b0;
        w_dec_mul  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: w_dec_ctrl = 6'b000000;
                    6'h24: w_dec_ctrl = 6'b000001;
                    6'h1A: begin w_dec_ctrl = 6'b000010; w_dec_div = 1'b1; end
                    6'h18: begin w_dec_ctrl = 6'b000011; w_dec_mul = 1'b1; end
                    6'h22: w_dec_ctrl = 6'b000100;
                    6'h25: w_dec_ctrl = 6'b000101;
                    6'h27: w_dec_ctrl = 6'b000110;
                    6'h26: w_dec_ctrl = 6'b000111;
                    6'h2A: w_dec_ctrl = 6'b001000;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            6'h08: begin w_dec_ctrl = 6'b000000; w_dec_imm = 1'b1; end
            6'h0C: begin w_dec_ctrl = 6'b000001; w_dec_imm = 1'b1; end
            6'h0D: begin w_dec_ctrl = 6'b000101; w_dec_imm = 1'b1; end
            6'h0E: begin w_dec_ctrl = 6'b000111; w_dec_imm = 1'b1; end
            6'h0A: begin w_dec_ctrl = 6'b001000; w_dec_imm = 1'b1; end
            6'h23: begin w_dec_ctrl = 6'b000000; w_dec_imm = 1'b1; end
            6'h2B: begin w_dec_ctrl = 6'b000000; w_dec_imm = 1'b1; end
            6'h04: w_dec_ctrl = 6'b000100;
            default: w_dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    if (w_dec_div && (c_div_cycles != 4'd0)) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_div_cycles;
                    end else if (w_dec_mul && (c_mul_cycles != 4'd0)) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_mul_cycles;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = 4'd0;
                    end
                end else if ((r_state == ST_HOLD) && out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ctrl  <= 6'b000000;
            r_imm   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_ctrl <= w_dec_ctrl;
                r_imm  <= w_dec_imm;
                r_ill  <= w_dec_ill;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_issuer
// Brief   : Scoreboard bench for alu_op_issuer: decode table, latency,
//           back-to-back streaming, back-pressure and mid-operation reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_op_issuer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] alu_control;
    logic       alu_src_imm;
    logic       illegal;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;

    alu_op_issuer #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_src_imm (alu_src_imm),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Advance to the sampling point just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [7:0] exp);
        opcode   = op;
        funct    = fn;
        in_valid = 1'b1;
        sb.push_back(exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, alu_control, alu_src_imm, illegal} !== 10'b1_0_000000_0_0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b ctl=%b imm=%b ill=%b, want 1 0 000000 0 0",
                     in_ready, out_valid, alu_control, alu_src_imm, illegal);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        send(6'h00, 6'h22, {6'b000100, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {alu_control, alu_src_imm, illegal} !== exp_v) begin
            errors++;
            $display("FAIL sub: got vld=%b out=%b, want vld=1 out=%b", out_valid,
                     {alu_control, alu_src_imm, illegal}, exp_v);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_retire: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0C, 6'h0E, 6'h2B, 6'h04, 6'h00, 6'h3F};
        logic [5:0] fns[12] = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h20};
        logic [7:0] exs[12] = '{8'b000000_0_0, 8'b000001_0_0, 8'b000101_0_0, 8'b000110_0_0,
                                8'b000111_0_0, 8'b001000_0_0, 8'b000001_1_0, 8'b000111_1_0,
                                8'b000000_1_0, 8'b000100_0_0, 8'b000000_0_1, 8'b000000_0_1};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(ops[i], fns[i], exs[i]);
            tick();
            in_valid = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {alu_control, alu_src_imm, illegal} !== exp_v) begin
                errors++;
                $display("FAIL decode[%0d] op=%h fn=%h: got vld=%b out=%b, want vld=1 out=%b",
                         i, ops[i], fns[i], out_valid, {alu_control, alu_src_imm, illegal}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_multicycle(input logic [5:0] fn, input int waits, input logic [5:0] ctl);
        out_ready = 1'b1;
        send(6'h00, fn, {ctl, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= waits; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait fn=%h cycle k+%0d: got rdy=%b vld=%b, want 0 0",
                         fn, i, in_ready, out_valid);
            end
            tick();
        end
        exp_v = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {alu_control, alu_src_imm, illegal} !== exp_v) begin
            errors++;
            $display("FAIL issue fn=%h: got vld=%b out=%b, want vld=1 out=%b", fn, out_valid,
                     {alu_control, alu_src_imm, illegal}, exp_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[3] = '{6'h08, 6'h0D, 6'h0A};
        logic [7:0] exs[3] = '{8'b000000_1_0, 8'b000101_1_0, 8'b001000_1_0};
        out_ready = 1'b1;
        send(ops[0], 6'h00, exs[0]);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {alu_control, alu_src_imm, illegal} !== exp_v) begin
                errors++;
                $display("FAIL b2b[%0d]: got vld=%b out=%b, want vld=1 out=%b", i - 1, out_valid,
                         {alu_control, alu_src_imm, illegal}, exp_v);
            end
            if (i < 3) begin
                send(ops[i], 6'h00, exs[i]);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b, want 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(6'h23, 6'h00, {6'b000000, 1'b1, 1'b0});
        tick();
        in_valid = 1'b1;
        opcode   = 6'h22;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_control !== 6'b000000 || alu_src_imm !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b ctl=%b imm=%b, want 1 0 000000 1",
                         i, out_valid, in_ready, alu_control, alu_src_imm);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || {alu_control, alu_src_imm, illegal} !== exp_v) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b vld=%b out=%b, want 1 1 %b", in_ready, out_valid,
                     {alu_control, alu_src_imm, illegal}, exp_v);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_retire: got vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h18;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, alu_control, alu_src_imm, illegal} !== 10'b1_0_000000_0_0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b vld=%b ctl=%b imm=%b ill=%b, want 1 0 000000 0 0",
                     in_ready, out_valid, alu_control, alu_src_imm, illegal);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_after[%0d]: got vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_decode();
        test_multicycle(6'h1A, 8, 6'b000010);
        test_multicycle(6'h18, 2, 6'b000011);
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
